// File: rtl/selector_pkg.sv
// selector_pkg: shared constants, state type and pointer helpers for the
// round-robin selector.
//   ACT_HIGH / ACT_LOW        : request/grant polarity choices
//   MSB_DISABLE / MSB_ENABLE  : search direction (ascending / descending)
//   sel_state_t               : output register occupancy
//   wrap_inc / wrap_dec       : modulo-n pointer step
package selector_pkg;

   localparam bit ACT_HIGH    = 1'b1;
   localparam bit ACT_LOW     = 1'b0;
   localparam bit MSB_DISABLE = 1'b0;
   localparam bit MSB_ENABLE  = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } sel_state_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   function automatic int wrap_dec(input int idx, input int n);
      return (idx == 0) ? n - 1 : idx - 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority search.
// The request vector is rotated so that the pointer position lands at
// offset 0 (walking in the configured direction), the lowest set offset is
// found, and that offset is mapped back to an element index.
//   req        in  IN       requests, active-high
//   ptr        in  LOG2_IN  search start position (< IN)
//   any        out 1        at least one request present
//   win_idx    out LOG2_IN  index of the winning element
//   win_onehot out IN       one-hot winner (all zero when no request)
module rr_pick
   import selector_pkg::*;
#(
   parameter int IN      = 8,
   parameter bit MSB     = MSB_DISABLE,
   parameter int LOG2_IN = (IN > 1) ? $clog2(IN) : 1
) (
   input  logic [IN-1:0]      req,
   input  logic [LOG2_IN-1:0] ptr,
   output logic               any,
   output logic [LOG2_IN-1:0] win_idx,
   output logic [IN-1:0]      win_onehot
);

   // Element index reached after k steps from p in the search direction.
   function automatic int pos(input int p, input int k);
      int t;
      if (MSB == MSB_ENABLE) begin
         t = p - k;
         if (t < 0) t = t + IN;
      end else begin
         t = p + k;
         if (t >= IN) t = t - IN;
      end
      return t;
   endfunction

   logic [IN-1:0] rot;
   logic          found;
   int            off;
   int            win;

   always_comb begin
      rot        = '0;
      found      = 1'b0;
      off        = 0;
      win        = 0;
      win_onehot = '0;
      for (int k = 0; k < IN; k++) begin
         rot[k] = req[pos(int'(ptr), k)];
      end
      // Walk downwards so the lowest set offset is the one left standing.
      for (int k = IN - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      win = pos(int'(ptr), off);
      if (found) win_onehot[win] = 1'b1;
   end

   assign any     = found;
   assign win_idx = LOG2_IN'(win);

endmodule

// File: rtl/rr_selector.sv
// rr_selector: registered round-robin selector with a valid/ready output.
// One requesting element is chosen per cycle with a rotating priority
// pointer and captured into the output register.
// Optional feature macro: RR_SELECTOR_LOCK_EN adds the 'lock' input, which
// keeps the pointer on a locked winner so it wins again (bursts).
//   clk       in  1        clock
//   reset_    in  1        asynchronous reset, active-low
//   req       in  IN       per-element request, polarity ACT
//   in        in  IN*DATA  element data, element i at [i*DATA +: DATA]
//   lock      in  IN       (RR_SELECTOR_LOCK_EN only) hold pointer on winner
//   gnt       out IN       one-hot grant, polarity ACT, capture cycle only
//   out_valid out 1        output register holds an element
//   out_ready in  1        consumer accepts out_data
//   out_data  out DATA     selected element
//   out_idx   out LOG2_IN  index of the selected element
module rr_selector
   import selector_pkg::*;
#(
   parameter int DATA    = 32,
   parameter int IN      = 8,
   parameter bit ACT     = ACT_HIGH,
   parameter bit MSB     = MSB_DISABLE,
   parameter int LOG2_IN = (IN > 1) ? $clog2(IN) : 1
) (
   input  logic               clk,
   input  logic               reset_,
   input  logic [IN-1:0]      req,
   input  logic [IN*DATA-1:0] in,
`ifdef RR_SELECTOR_LOCK_EN
   input  logic [IN-1:0]      lock,
`endif
   output logic [IN-1:0]      gnt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA-1:0]    out_data,
   output logic [LOG2_IN-1:0] out_idx
);

   // Descending search starts at the top element after reset.
   localparam logic [LOG2_IN-1:0] PTR_RST =
      (MSB == MSB_ENABLE) ? LOG2_IN'(IN - 1) : '0;

   sel_state_t         state_q, state_d;
   logic [LOG2_IN-1:0] ptr_q, ptr_d;
   logic [IN-1:0]      req_h;
   logic [IN-1:0]      gnt_h;
   logic [IN-1:0]      win_onehot;
   logic [LOG2_IN-1:0] win_idx;
   logic               any_req;
   logic               cap;

   assign req_h = (ACT == ACT_HIGH) ? req : ~req;

   rr_pick #(
      .IN      (IN),
      .MSB     (MSB),
      .LOG2_IN (LOG2_IN)
   ) u_pick (
      .req        (req_h),
      .ptr        (ptr_q),
      .any        (any_req),
      .win_idx    (win_idx),
      .win_onehot (win_onehot)
   );

   // Capture when the register is free now or is being drained this cycle.
   assign cap   = ((state_q == EMPTY) || out_ready) && any_req;
   assign gnt_h = cap ? win_onehot : '0;
   assign gnt   = (ACT == ACT_HIGH) ? gnt_h : ~gnt_h;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         EMPTY:   if (cap) state_d = FULL;
         FULL:    if (out_ready && !cap) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (cap) begin
         if (MSB == MSB_ENABLE) ptr_d = LOG2_IN'(wrap_dec(int'(win_idx), IN));
         else                   ptr_d = LOG2_IN'(wrap_inc(int'(win_idx), IN));
`ifdef RR_SELECTOR_LOCK_EN
         if (lock[win_idx]) ptr_d = win_idx;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= EMPTY;
         ptr_q    <= PTR_RST;
         out_data <= '0;
         out_idx  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (cap) begin
            out_data <= in[int'(win_idx)*DATA +: DATA];
            out_idx  <= win_idx;
         end
      end
   end

   assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_selector.sv
// Directed bench for rr_selector: three instances cover the default
// configuration (8 inputs, ascending, active-high), a 5-input ascending
// selector and an 8-input descending active-low selector.
module tb_rr_selector;
   import selector_pkg::*;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   // Instance A: IN=8, DATA=32, ascending, active-high
   logic [7:0]   req_a, gnt_a, lock_a;
   logic [255:0] in_a;
   logic         rdy_a, vld_a;
   logic [31:0]  data_a;
   logic [2:0]   idx_a;

   // Instance B: IN=5, DATA=8, ascending, active-high
   logic [4:0]   req_b, gnt_b;
   logic [39:0]  in_b;
   logic         rdy_b, vld_b;
   logic [7:0]   data_b;
   logic [2:0]   idx_b;

   // Instance C: IN=8, DATA=16, descending, active-low
   logic [7:0]   req_c, gnt_c;
   logic [127:0] in_c;
   logic         rdy_c, vld_c;
   logic [15:0]  data_c;
   logic [2:0]   idx_c;

   int total = 0;
   int bad   = 0;
   int eb[4] = '{0, 4, 0, 4};
   int ec[3] = '{7, 5, 7};
   logic [7:0] e8;

   rr_selector #(.DATA(32), .IN(8), .ACT(ACT_HIGH), .MSB(MSB_DISABLE)) dut_a (
      .clk(clk), .reset_(reset_), .req(req_a), .in(in_a),
`ifdef RR_SELECTOR_LOCK_EN
      .lock(lock_a),
`endif
      .gnt(gnt_a), .out_valid(vld_a), .out_ready(rdy_a),
      .out_data(data_a), .out_idx(idx_a)
   );

   rr_selector #(.DATA(8), .IN(5), .ACT(ACT_HIGH), .MSB(MSB_DISABLE)) dut_b (
      .clk(clk), .reset_(reset_), .req(req_b), .in(in_b),
`ifdef RR_SELECTOR_LOCK_EN
      .lock(5'b0),
`endif
      .gnt(gnt_b), .out_valid(vld_b), .out_ready(rdy_b),
      .out_data(data_b), .out_idx(idx_b)
   );

   rr_selector #(.DATA(16), .IN(8), .ACT(ACT_LOW), .MSB(MSB_ENABLE)) dut_c (
      .clk(clk), .reset_(reset_), .req(req_c), .in(in_c),
`ifdef RR_SELECTOR_LOCK_EN
      .lock(8'b0),
`endif
      .gnt(gnt_c), .out_valid(vld_c), .out_ready(rdy_c),
      .out_data(data_c), .out_idx(idx_c)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_ = 1'b0;
      req_a = '0; rdy_a = 1'b0; lock_a = '0;
      req_b = '0; rdy_b = 1'b0;
      req_c = '1; rdy_c = 1'b0;
      for (int i = 0; i < 8; i++) in_a[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 5; i++) in_b[i*8 +: 8]   = 8'h50 + 8'(i);
      for (int i = 0; i < 8; i++) in_c[i*16 +: 16] = 16'hC000 + 16'(i);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_vld_a",  64'(vld_a),  64'(0));
      chk("rst_data_a", 64'(data_a), 64'(0));
      chk("rst_idx_a",  64'(idx_a),  64'(0));
      chk("rst_gnt_a",  64'(gnt_a),  64'(0));
      chk("rst_vld_c",  64'(vld_c),  64'(0));
      chk("rst_gnt_c",  64'(gnt_c),  64'h00FF);

      // All requests, consumer always ready: 0..7 then wrap to 0
      reset_ = 1'b1;
      req_a  = 8'hFF;
      rdy_a  = 1'b1;
      for (int k = 0; k < 9; k++) begin
         #1 chk("rr_gnt_a", 64'(gnt_a), 64'(1) << (k % 8));
         @(negedge clk);
         chk("rr_idx_a",  64'(idx_a),  64'(k % 8));
         chk("rr_data_a", 64'(data_a), 64'(32'hA000_0000 + 32'(k % 8)));
         chk("rr_vld_a",  64'(vld_a),  64'(1));
      end

      // Back-pressure for 3 cycles: outputs hold, no grant
      rdy_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_gnt_a", 64'(gnt_a), 64'(0));
         @(negedge clk);
         chk("bp_idx_a",  64'(idx_a),  64'(0));
         chk("bp_data_a", 64'(data_a), 64'h0000_0000_A000_0000);
         chk("bp_vld_a",  64'(vld_a),  64'(1));
      end
      rdy_a = 1'b1;
      #1 chk("rel_gnt_a", 64'(gnt_a), 64'h02);
      @(negedge clk);
      chk("rel_idx_a", 64'(idx_a), 64'(1));

      // Drain with no requests, then pointer still continues from 2
      req_a = '0;
      #1 chk("drain_gnt_a", 64'(gnt_a), 64'(0));
      @(negedge clk);
      chk("drain_vld_a", 64'(vld_a), 64'(0));
      req_a = 8'hFF;
      #1 chk("hold_gnt_a", 64'(gnt_a), 64'h04);
      @(negedge clk);
      chk("hold_idx_a", 64'(idx_a), 64'(2));
      chk("hold_vld_a", 64'(vld_a), 64'(1));
      req_a = '0;
      rdy_a = 1'b0;

      // IN=5, elements 0 and 4: alternate 0,4,0,4 with wrap 4->0
      req_b = 5'b10001;
      rdy_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk("b_gnt", 64'(gnt_b), 64'(1) << eb[k]);
         @(negedge clk);
         chk("b_idx",  64'(idx_b),  64'(eb[k]));
         chk("b_data", 64'(data_b), 64'(8'h50 + 8'(eb[k])));
      end
      req_b = '0;

      // Descending, active-low, elements 5 and 7: 7,5,7
      req_c = 8'b0101_1111;
      rdy_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
         e8 = ~(8'(1) << ec[k]);
         #1 chk("c_gnt", 64'(gnt_c), 64'(e8));
         @(negedge clk);
         chk("c_idx",  64'(idx_c),  64'(ec[k]));
         chk("c_data", 64'(data_c), 64'(16'hC000 + 16'(ec[k])));
         chk("c_vld",  64'(vld_c),  64'(1));
      end
      req_c = '1;

      // Asynchronous reset while A is full and stalled
      chk("pre_rst_vld_a", 64'(vld_a), 64'(1));
      #2 reset_ = 1'b0;
      #1 chk("arst_vld_a", 64'(vld_a), 64'(0));
      chk("arst_idx_a",  64'(idx_a),  64'(0));
      chk("arst_data_a", 64'(data_a), 64'(0));
      @(negedge clk);
      reset_ = 1'b1;
      req_a  = 8'hFF;
      rdy_a  = 1'b1;
      #1 chk("post_rst_gnt_a", 64'(gnt_a), 64'h01);
      @(negedge clk);
      chk("post_rst_idx_a", 64'(idx_a), 64'(0));
      chk("post_rst_vld_a", 64'(vld_a), 64'(1));

`ifdef RR_SELECTOR_LOCK_EN
      // Element 2 locked while 3 also requests: 2 x4, unlocked 2, then 3
      req_a  = 8'h0C;
      lock_a = 8'h04;
      for (int k = 0; k < 4; k++) begin
         #1 chk("lock_gnt_a", 64'(gnt_a), 64'h04);
         @(negedge clk);
         chk("lock_idx_a", 64'(idx_a), 64'(2));
      end
      lock_a = '0;
      #1 chk("unlock_gnt_a", 64'(gnt_a), 64'h04);
      @(negedge clk);
      chk("unlock_idx_a", 64'(idx_a), 64'(2));
      #1 chk("next_gnt_a", 64'(gnt_a), 64'h08);
      @(negedge clk);
      chk("next_idx_a", 64'(idx_a), 64'(3));
`endif

      req_a = '0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
